// File: rtl/wb_arbiter_2.sv
// rtl/wb_arbiter_2.sv - two-master round-robin Wishbone arbiter onto one shared slave
// Optional stall timeout: define WB_ARB_TIMEOUT_EN.
module wb_arbiter_2 #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t state;
   logic   last_grant;
   logic   timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_LOG = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW      = (CNT_LOG < 8) ? 8 : CNT_LOG;

   logic [CW-1:0] stall_cnt;

   assign timeout_hit = (stall_cnt == CW'(TIMEOUT_CYCLES));

   // s_stb_o is already forced low on the timeout cycle, so the counter clears there
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         stall_cnt <= '0;
      else if (s_stb_o && !s_ack_i && !s_err_i)
         stall_cnt <= stall_cnt + 1'b1;
      else
         stall_cnt <= '0;
   end
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   // last_grant resets to 1 so that m0 wins the first contention
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
                  state      <= GNT0;
                  last_grant <= 1'b0;
               end else if (m1_cyc_i) begin
                  state      <= GNT1;
                  last_grant <= 1'b1;
               end
            end
            GNT0:    if (!m0_cyc_i) state <= IDLE;
            GNT1:    if (!m1_cyc_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = 4'h0;
      s_adr_o  = 32'h0;
      s_dat_o  = 32'h0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i && !timeout_hit;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i || timeout_hit;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i && !timeout_hit;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i || timeout_hit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2.sv
// tb/tb_wb_arbiter_2.sv - directed and random checks of wb_arbiter_2 against an ownership model
module tb_wb_arbiter_2;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
   logic [31:0] m0_rdat, m1_rdat;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic        s_ack, s_err;

   int n_checks = 0;
   int n_errors = 0;
   int owner    = -1;
   int rr_next  = 0;
   int stall    = 0;
   int ack0_seen, err0_seen;

   always #5 clk = ~clk;

   wb_arbiter_2 #(.TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i(clk),     .wb_rst_i(rst),
      .m0_cyc_i(m0_cyc),  .m0_stb_i(m0_stb), .m0_we_i(m0_we),  .m0_sel_i(m0_sel),
      .m0_adr_i(m0_adr),  .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat),
      .m0_ack_o(m0_ack),  .m0_err_o(m0_err),
      .m1_cyc_i(m1_cyc),  .m1_stb_i(m1_stb), .m1_we_i(m1_we),  .m1_sel_i(m1_sel),
      .m1_adr_i(m1_adr),  .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat),
      .m1_ack_o(m1_ack),  .m1_err_o(m1_err),
      .s_cyc_o(s_cyc),    .s_stb_o(s_stb),   .s_we_o(s_we),    .s_sel_o(s_sel),
      .s_adr_o(s_adr),    .s_dat_o(s_wdat),
      .s_dat_i(s_rdat),   .s_ack_i(s_ack),   .s_err_i(s_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      rst = 0;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dat = 0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dat = 0;
      s_rdat = 0; s_ack = 0; s_err = 0;
   endtask

   // Inputs are already driven (at a falling edge); check, then advance the model one cycle.
   task automatic step();
      logic        x_cyc, x_stb, x_we, to_hit;
      logic [3:0]  x_sel;
      logic [31:0] x_adr, x_dat;
      logic        a0, e0, a1, e1;
      to_hit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      to_hit = (owner >= 0) && (stall == TO);
`endif
      x_cyc = 0; x_stb = 0; x_we = 0; x_sel = 0; x_adr = 0; x_dat = 0;
      if (owner == 0) begin
         x_cyc = m0_cyc; x_stb = m0_stb; x_we = m0_we; x_sel = m0_sel; x_adr = m0_adr; x_dat = m0_dat;
      end else if (owner == 1) begin
         x_cyc = m1_cyc; x_stb = m1_stb; x_we = m1_we; x_sel = m1_sel; x_adr = m1_adr; x_dat = m1_dat;
      end
      if (to_hit) x_stb = 1'b0;
      a0 = (owner == 0) && s_ack;
      e0 = (owner == 0) && (s_err || to_hit);
      a1 = (owner == 1) && s_ack;
      e1 = (owner == 1) && (s_err || to_hit);
      #1;
      chk("s_ctl",  {s_cyc, s_stb, s_we, s_sel}, {x_cyc, x_stb, x_we, x_sel});
      chk("s_adr",  s_adr, x_adr);
      chk("s_wdat", s_wdat, x_dat);
      chk("m_resp", {m0_ack, m0_err, m1_ack, m1_err}, {a0, e0, a1, e1});
      chk("m_rdat", {m0_rdat, m1_rdat}, {s_rdat, s_rdat});
      ack0_seen += int'(m0_ack);
      err0_seen += int'(m0_err);
      @(posedge clk);
      if (rst) begin
         owner = -1; rr_next = 0; stall = 0;
      end else begin
         stall = (x_stb && !s_ack && !s_err) ? stall + 1 : 0;
         if (owner < 0) begin
            if (m0_cyc && m1_cyc) owner = rr_next;
            else if (m0_cyc)      owner = 0;
            else if (m1_cyc)      owner = 1;
            if (owner >= 0) rr_next = 1 - owner;
         end else if ((owner == 0 && !m0_cyc) || (owner == 1 && !m1_cyc)) begin
            owner = -1;
         end
      end
      @(negedge clk);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int exp_err;
      clear_inputs();
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      hold(2);
      rst = 0;
      #1;
      chk("reset_idle", {s_cyc, s_stb, m0_ack, m1_ack}, 4'b0000);
      @(negedge clk);

      // single read from m0, slave answers two cycles after the strobe reaches it
      m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_adr = 32'h3080_0004;
      hold(3);
      s_ack = 1; s_rdat = 32'hDEAD_BEEF;
      #1;
      chk("read_data", {m0_ack, m1_ack, m0_rdat}, {1'b1, 1'b0, 32'hDEAD_BEEF});
      step();
      clear_inputs();
      hold(2);

      // simultaneous requests: m0, idle gap, m1, then m0 again
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
      hold(3);
      m0_cyc = 0; m0_stb = 0;
      hold(4);
      chk("rr_m1_granted", s_adr, 32'h200);
      m1_cyc = 0; m1_stb = 0;
      hold(1);
      m0_cyc = 1; m1_cyc = 1;
      hold(2);
      chk("rr_m0_again", s_adr, 32'h100);
      clear_inputs();
      hold(2);

      // m1 locks the bus for four acked writes while m0 waits
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3;
      hold(1);
      m0_cyc = 1; m0_stb = 1;
      ack0_seen = 0;
      for (int i = 0; i < 4; i++) begin
         m1_adr = 32'h40 + 32'(i * 4); m1_dat = $urandom; s_ack = 1;
         step();
      end
      chk("m0_starved_acks", ack0_seen, 0);
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      hold(3);
      clear_inputs();
      hold(2);

      // reset while m1 holds the bus, then m0 must win the next contention
      m1_cyc = 1; m1_stb = 1;
      hold(3);
      rst = 1;
      step();
      rst = 0;
      #1;
      chk("rst_abort", {s_cyc, s_stb, m1_ack, m1_err}, 4'b0000);
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h111; m1_adr = 32'h222;
      hold(2);
      chk("rst_m0_first", s_adr, 32'h111);
      clear_inputs();
      hold(2);

      // slave never answers
      m0_cyc = 1; m0_stb = 1;
      err0_seen = 0;
      hold(14);
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      chk("timeout_err_count", err0_seen, exp_err);
      clear_inputs();
      hold(2);

      // slave ack while nobody is granted
      s_ack = 1; s_err = 1;
      #1;
      chk("idle_ack_ignored", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
      step();
      clear_inputs();

      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(63) == 0);
         m0_cyc = m0_cyc ? ($urandom_range(5) != 0) : ($urandom_range(3) == 0);
         m1_cyc = m1_cyc ? ($urandom_range(5) != 0) : ($urandom_range(3) == 0);
         m0_stb = m0_cyc && ($urandom_range(3) != 0);
         m1_stb = m1_cyc && ($urandom_range(3) != 0);
         m0_we = $urandom_range(1); m1_we = $urandom_range(1);
         m0_sel = 4'($urandom); m1_sel = 4'($urandom);
         m0_adr = $urandom; m1_adr = $urandom;
         m0_dat = $urandom; m1_dat = $urandom;
         s_rdat = $urandom;
         s_ack = ($urandom_range(2) == 0);
         s_err = ($urandom_range(10) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2.md
WB_ARBITER_2 -- requirements
Module: wb_arbiter_2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning stalled-strobe cycle count before the arbiter self-terminates a transfer.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports m0_cyc_i/m1_cyc_i  input  1  master N bus cycle request.
REQ-005 SHALL have ports m0_stb_i/m1_stb_i  input  1  master N strobe.
REQ-006 SHALL have ports m0_we_i/m1_we_i  input  1  master N write enable.
REQ-007 SHALL have ports m0_sel_i/m1_sel_i  input  4  master N byte selects.
REQ-008 SHALL have ports m0_adr_i/m1_adr_i  input  32  master N address.
REQ-009 SHALL have ports m0_dat_i/m1_dat_i  input  32  master N write data.
REQ-010 SHALL have ports m0_dat_o/m1_dat_o  output  32  read data to master N.
REQ-011 SHALL have ports m0_ack_o/m1_ack_o  output  1  acknowledge to master N.
REQ-012 SHALL have ports m0_err_o/m1_err_o  output  1  error to master N.
REQ-013 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1 each  shared-slave control.
REQ-014 SHALL have ports s_sel_o  output  4, s_adr_o  output  32, s_dat_o  output  32  shared-slave selects/address/write data.
REQ-015 SHALL have ports s_dat_i  input  32, s_ack_i  input  1, s_err_i  input  1  shared-slave response.

Function
REQ-016 SHALL implement FSM states IDLE, GNT0, GNT1 plus 1-bit last_grant register.
REQ-017 IDLE: only m0_cyc_i high -> GNT0; only m1_cyc_i high -> GNT1; neither -> stay IDLE.
REQ-018 IDLE with both cyc high SHALL grant the master not equal to last_grant (round-robin); last_grant updates on entering GNTx.
REQ-019 Grant latency SHALL be exactly one cycle: request sampled in IDLE, slave sees master signals from the following cycle.
REQ-020 GNTx SHALL hold while mx_cyc_i is high, regardless of the other master; mx_cyc_i low -> IDLE next edge (minimum one IDLE cycle between grants).
REQ-021 In GNTx, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally follow master x; in IDLE all SHALL be 0.
REQ-022 s_ack_i/s_err_i SHALL route only to the granted master; non-granted master ack/err SHALL be 0; both mN_dat_o SHALL carry s_dat_i.
REQ-023 Non-granted master SHALL see no ack/err and stall indefinitely until granted.
REQ-024 Granted master dropping cyc in the same cycle the other raises cyc SHALL yield IDLE then grant to the other, no lost request.
REQ-025 s_ack_i or s_err_i asserted while in IDLE SHALL be ignored.

Reset
REQ-026 On wb_rst_i high at a clock edge: state IDLE, last_grant=1 (m0 wins first contention), timeout counter 0.
REQ-027 Reset mid-transfer SHALL abort the grant; from the next cycle all s_* outputs and mN_ack_o/mN_err_o are 0.
REQ-028 While wb_rst_i high, no grant SHALL be issued.

Configuration
REQ-029 Macro WB_ARB_TIMEOUT_EN SHALL compile in an 8-bit-min stall counter (width ceil(log2(TIMEOUT_CYCLES+1))).
REQ-030 With WB_ARB_TIMEOUT_EN: counter increments each cycle s_stb_o high with s_ack_i and s_err_i low, clears otherwise; reaching TIMEOUT_CYCLES SHALL pulse granted master's err_o for one cycle, clear counter, force s_stb_o low that cycle.
REQ-031 Without WB_ARB_TIMEOUT_EN: no counter; stalled transfer holds grant forever; mN_err_o equals routed s_err_i only.

Verification
REQ-032 m0 single read adr 0x3080_0004, slave acks data 0xDEAD_BEEF 2 cycles after strobe -> s_adr_o valid 1 cycle after cyc, m0_dat_o=0xDEAD_BEEF with m0_ack_o, m1_ack_o=0.
REQ-033 m0 and m1 raise cyc same cycle after reset -> GNT0 first; after m0 drops cyc, one IDLE cycle, then GNT1; next contention -> GNT0.
REQ-034 m1 holds cyc for 4 back-to-back acked writes while m0 requests -> m0 ungranted, zero acks, until m1 cyc drops.
REQ-035 wb_rst_i pulsed during GNT1 with stb high -> next cycle s_cyc_o=0, s_stb_o=0, m1_ack_o=0; later contention grants m0 first.
REQ-036 With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o high for exactly one cycle 8 cycles after strobe; without macro, no err, grant held.
REQ-037 s_ack_i forced high in IDLE -> both mN_ack_o remain 0.
